// File: rtl/lmsm_sequencer.sv
// Load/store-multiple sequencer: walks a register bitmap in ascending order and moves each
// selected register to/from consecutive memory addresses through a ready-handshaked port.
module lmsm_sequencer #(
    parameter int unsigned NREG = 8,
    parameter int unsigned AW   = 16,
    parameter int unsigned DW   = 16,
    localparam int unsigned IW  = $clog2(NREG),
    localparam int unsigned CW  = $clog2(NREG + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            mode,
    input  logic [NREG-1:0] mask,
    input  logic [AW-1:0]   base_addr,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_ready,
    input  logic [DW-1:0]   mem_rdata,
    output logic [IW-1:0]   rf_raddr,
    input  logic [DW-1:0]   rf_rdata,
    output logic            rf_we,
    output logic [IW-1:0]   rf_waddr,
    output logic [DW-1:0]   rf_wdata,
    output logic            busy,
    output logic            done,
    output logic [CW-1:0]   xfer_count
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] SCAN = 3'd1;
    localparam logic [2:0] ACC  = 3'd2;
    localparam logic [2:0] WB   = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [NREG-1:0] pend_q, pend_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic            mode_q, mode_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   data_q, data_d;

    logic [IW-1:0]   low_idx;
    logic [NREG-1:0] pend_clr;

    // Priority pick of the lowest pending register; later (lower) indices overwrite.
    always_comb begin
        low_idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                low_idx = IW'(i);
            end
        end
    end

    assign pend_clr = pend_q & ~(NREG'(1) << idx_q);

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        ptr_d   = ptr_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pend_d  = mask;
                    ptr_d   = base_addr;
                    mode_d  = mode;
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (pend_q == '0) begin
                    state_d = DONE;
                end else begin
                    idx_d   = low_idx;
                    state_d = ACC;
                end
            end
            ACC: begin
                if (mem_ready) begin
                    if (mode_q) begin
                        pend_d  = pend_clr;
                        ptr_d   = ptr_q + AW'(1);
                        cnt_d   = cnt_q + CW'(1);
                        state_d = SCAN;
                    end else begin
                        data_d  = mem_rdata;
                        state_d = WB;
                    end
                end
            end
            WB: begin
                pend_d  = pend_clr;
                ptr_d   = ptr_q + AW'(1);
                cnt_d   = cnt_q + CW'(1);
                state_d = SCAN;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            ptr_q   <= '0;
            mode_q  <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // Outputs are decoded from registered state; data/address buses read zero when inactive.
    always_comb begin
        mem_req    = (state_q == ACC);
        mem_we     = mem_req & mode_q;
        mem_addr   = mem_req ? ptr_q : '0;
        mem_wdata  = mem_we ? rf_rdata : '0;
        rf_raddr   = idx_q;
        rf_we      = (state_q == WB);
        rf_waddr   = rf_we ? idx_q : '0;
        rf_wdata   = rf_we ? data_q : '0;
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        xfer_count = cnt_q;
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(mem_req && rf_we));

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer with behavioural memory and register-file models.
module tb_lmsm_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [7:0]  mask;
    logic [15:0] base_addr;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic [2:0]  rf_raddr;
    logic [15:0] rf_rdata;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        busy;
    logic        done;
    logic [3:0]  xfer_count;

    logic [15:0] mem [0:65535];
    logic [15:0] rf  [0:7];

    int vectors;
    int miscompares;

    logic [15:0] acc_addr [$];
    logic [15:0] wr_data  [$];
    logic [2:0]  rf_wa    [$];
    logic [15:0] rf_wd    [$];
    logic        both_seen;
    logic        stable_ok;
    int          acc_cycles;
    logic        done_after;
    logic        busy_after;

    lmsm_sequencer #(.NREG(8), .AW(16), .DW(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .mask       (mask),
        .base_addr  (base_addr),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .rf_raddr   (rf_raddr),
        .rf_rdata   (rf_rdata),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .busy       (busy),
        .done       (done),
        .xfer_count (xfer_count)
    );

    assign mem_rdata = mem[mem_addr];
    assign rf_rdata  = rf[rf_raddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mem[a] = a ^ 5A5A, rf[i] = C000 + i*0101
    task automatic init_models();
        for (int a = 0; a < 65536; a++) mem[a] = 16'(a) ^ 16'h5A5A;
        for (int i = 0; i < 8; i++) rf[i] = 16'hC000 + 16'(i) * 16'h0101;
    endtask

    task automatic run_op(input logic m, input logic [7:0] mk, input logic [15:0] ba,
                          input int stall, output int cycles);
        logic        got;
        logic        have_ref;
        logic [15:0] ref_addr;
        logic [15:0] ref_wdata;
        int          stall_left;
        acc_addr.delete();
        wr_data.delete();
        rf_wa.delete();
        rf_wd.delete();
        both_seen  = 1'b0;
        stable_ok  = 1'b1;
        acc_cycles = 0;
        have_ref   = 1'b0;
        ref_addr   = '0;
        ref_wdata  = '0;
        stall_left = stall;
        @(negedge clk);
        start = 1'b1; mode = m; mask = mk; base_addr = ba;
        @(posedge clk);
        #1 start = 1'b0;
        cycles = 1;
        got = 1'b0;
        while (!got && cycles < 300) begin
            @(negedge clk);
            cycles++;
            if (mem_req && rf_we) both_seen = 1'b1;
            if (mem_req) begin
                acc_cycles++;
                if (!have_ref) begin
                    ref_addr = mem_addr; ref_wdata = mem_wdata; have_ref = 1'b1;
                end else if (mem_addr !== ref_addr || mem_wdata !== ref_wdata) begin
                    stable_ok = 1'b0;
                end
                if (stall_left > 0) begin
                    mem_ready = 1'b0;
                    stall_left--;
                end else begin
                    mem_ready = 1'b1;
                    acc_addr.push_back(mem_addr);
                    if (mem_we) begin
                        wr_data.push_back(mem_wdata);
                        mem[mem_addr] = mem_wdata;
                    end
                    have_ref = 1'b0;
                end
            end else begin
                mem_ready = 1'b1;
            end
            if (rf_we) begin
                rf_wa.push_back(rf_waddr);
                rf_wd.push_back(rf_wdata);
                rf[rf_waddr] = rf_wdata;
            end
            if (done) got = 1'b1;
        end
        vectors++;
        if (!got) begin
            $display("FAIL op_timeout: done not seen after %0d cycles, required within 300", cycles);
            miscompares++;
        end
        @(negedge clk);
        done_after = done;
        busy_after = busy;
    endtask

    task automatic test_reset();
        vectors++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, rf_raddr, rf_we, rf_waddr, rf_wdata,
             busy, done, xfer_count} !== 63'd0) begin
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h busy=%b done=%b cnt=%0d, required all 0",
                     mem_req, mem_we, mem_addr, busy, done, xfer_count);
            miscompares++;
        end
    endtask

    task automatic test_store();
        int cyc;
        init_models();
        run_op(1'b1, 8'h81, 16'h0100, 0, cyc);
        vectors++;
        if (cyc !== 7) begin
            $display("FAIL store_latency: got %0d cycles, required 7", cyc); miscompares++;
        end
        vectors++;
        if (acc_addr.size() !== 2 || acc_addr[0] !== 16'h0100 || acc_addr[1] !== 16'h0101) begin
            $display("FAIL store_addr: got n=%0d %h %h, required 0100 0101",
                     acc_addr.size(), acc_addr[0], acc_addr[1]); miscompares++;
        end
        vectors++;
        if (wr_data.size() !== 2 || wr_data[0] !== 16'hC000 || wr_data[1] !== 16'hC707) begin
            $display("FAIL store_data: got n=%0d %h %h, required C000 C707",
                     wr_data.size(), wr_data[0], wr_data[1]); miscompares++;
        end
        vectors++;
        if (xfer_count !== 4'd2 || rf_wa.size() !== 0) begin
            $display("FAIL store_count: got cnt=%0d rf_writes=%0d, required 2 and 0",
                     xfer_count, rf_wa.size()); miscompares++;
        end
        vectors++;
        if (done_after !== 1'b0 || busy_after !== 1'b0) begin
            $display("FAIL done_pulse: got done=%b busy=%b after pulse, required 0 0",
                     done_after, busy_after); miscompares++;
        end
    endtask

    task automatic test_load();
        int cyc;
        init_models();
        run_op(1'b0, 8'h0E, 16'h0020, 0, cyc);
        vectors++;
        if (cyc !== 12) begin
            $display("FAIL load_latency: got %0d cycles, required 12", cyc); miscompares++;
        end
        vectors++;
        if (rf_wa.size() !== 3 || rf_wa[0] !== 3'd1 || rf_wa[1] !== 3'd2 || rf_wa[2] !== 3'd3) begin
            $display("FAIL load_waddr: got n=%0d %0d %0d %0d, required 1 2 3",
                     rf_wa.size(), rf_wa[0], rf_wa[1], rf_wa[2]); miscompares++;
        end
        vectors++;
        if (rf_wd.size() !== 3 || rf_wd[0] !== 16'h5A7A || rf_wd[1] !== 16'h5A7B
            || rf_wd[2] !== 16'h5A78) begin
            $display("FAIL load_wdata: got %h %h %h, required 5A7A 5A7B 5A78",
                     rf_wd[0], rf_wd[1], rf_wd[2]); miscompares++;
        end
        vectors++;
        if (acc_addr.size() !== 3 || acc_addr[0] !== 16'h0020 || acc_addr[2] !== 16'h0022
            || wr_data.size() !== 0) begin
            $display("FAIL load_addr: got n=%0d %h..%h writes=%0d, required 3 0020..0022 0",
                     acc_addr.size(), acc_addr[0], acc_addr[2], wr_data.size()); miscompares++;
        end
        vectors++;
        if (xfer_count !== 4'd3 || both_seen !== 1'b0) begin
            $display("FAIL load_count: got cnt=%0d overlap=%b, required 3 0",
                     xfer_count, both_seen); miscompares++;
        end
    endtask

    task automatic test_wait_states();
        int cyc;
        init_models();
        run_op(1'b1, 8'h01, 16'h0300, 4, cyc);
        vectors++;
        if (acc_cycles !== 5 || stable_ok !== 1'b1) begin
            $display("FAIL wait_hold: got acc_cycles=%0d stable=%b, required 5 1",
                     acc_cycles, stable_ok); miscompares++;
        end
        vectors++;
        if (wr_data.size() !== 1 || wr_data[0] !== 16'hC000 || acc_addr[0] !== 16'h0300) begin
            $display("FAIL wait_write: got n=%0d data=%h addr=%h, required 1 C000 0300",
                     wr_data.size(), wr_data[0], acc_addr[0]); miscompares++;
        end
        vectors++;
        if (cyc !== 9 || xfer_count !== 4'd1) begin
            $display("FAIL wait_latency: got %0d cycles cnt=%0d, required 9 1",
                     cyc, xfer_count); miscompares++;
        end
    endtask

    task automatic test_empty();
        int cyc;
        init_models();
        run_op(1'b1, 8'h00, 16'h1234, 0, cyc);
        vectors++;
        if (cyc !== 3) begin
            $display("FAIL empty_latency: got %0d cycles, required 3", cyc); miscompares++;
        end
        vectors++;
        if (acc_cycles !== 0 || rf_wa.size() !== 0 || xfer_count !== 4'd0) begin
            $display("FAIL empty_activity: got req_cycles=%0d rf_writes=%0d cnt=%0d, required 0 0 0",
                     acc_cycles, rf_wa.size(), xfer_count); miscompares++;
        end
    endtask

    task automatic test_wrap();
        int cyc;
        init_models();
        run_op(1'b0, 8'h03, 16'hFFFF, 0, cyc);
        vectors++;
        if (acc_addr.size() !== 2 || acc_addr[0] !== 16'hFFFF || acc_addr[1] !== 16'h0000) begin
            $display("FAIL wrap_addr: got n=%0d %h %h, required FFFF 0000",
                     acc_addr.size(), acc_addr[0], acc_addr[1]); miscompares++;
        end
        vectors++;
        if (rf_wd.size() !== 2 || rf_wd[0] !== 16'hA5A5 || rf_wd[1] !== 16'h5A5A) begin
            $display("FAIL wrap_data: got n=%0d %h %h, required A5A5 5A5A",
                     rf_wd.size(), rf_wd[0], rf_wd[1]); miscompares++;
        end
    endtask

    task automatic test_abort_restart();
        int cyc;
        init_models();
        mem_ready = 1'b1;
        @(negedge clk);
        start = 1'b1; mode = 1'b1; mask = 8'hFF; base_addr = 16'h0040;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        start = 1'b1; mode = 1'b0; mask = 8'h00; base_addr = 16'h9000;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        vectors++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0041 || busy !== 1'b1) begin
            $display("FAIL busy_start_ignored: got req=%b we=%b addr=%h, required 1 1 0041",
                     mem_req, mem_we, mem_addr); miscompares++;
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, rf_raddr, rf_we, rf_waddr, rf_wdata,
             busy, done, xfer_count} !== 63'd0) begin
            $display("FAIL abort_outputs: got req=%b addr=%h busy=%b cnt=%0d, required all 0",
                     mem_req, mem_addr, busy, xfer_count); miscompares++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b1, 8'hFF, 16'h0080, 0, cyc);
        vectors++;
        if (xfer_count !== 4'd8 || cyc !== 19 || wr_data.size() !== 8) begin
            $display("FAIL restart_count: got cnt=%0d cycles=%0d writes=%0d, required 8 19 8",
                     xfer_count, cyc, wr_data.size()); miscompares++;
        end
        vectors++;
        if (wr_data[7] !== 16'hC707 || acc_addr[7] !== 16'h0087 || wr_data[3] !== 16'hC303) begin
            $display("FAIL restart_data: got R7=%h@%h R3=%h, required C707@0087 C303",
                     wr_data[7], acc_addr[7], wr_data[3]); miscompares++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        mode        = 1'b0;
        mask        = 8'h00;
        base_addr   = 16'h0000;
        mem_ready   = 1'b1;
        init_models();
        #3;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_store();
        test_load();
        test_wait_states();
        test_empty();
        test_wrap();
        test_abort_restart();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
